// File: rtl/penc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// penc_rr_arbiter
//
// N-requester arbiter built around a priority-encoder core. It registers
// grant, grant_idx and grant_valid, holds a grant for as long as the owner
// keeps its request high, and arbitrates either by fixed priority or by
// round-robin.
//
// Parameters:
//   N        number of requesters (>= 2)
//   IDX_W    width of grant_idx, derived as $clog2(N); leave at its default
//   MODE     0 = fixed priority (highest index wins), 1 = round-robin
//   MAX_HOLD longest grant in cycles; only used when ARB_TIMEOUT_EN is defined
//
// Compile-time option:
//   ARB_TIMEOUT_EN  when defined, a hold counter force-revokes any grant held
//                   for MAX_HOLD cycles and pulses timeout for one cycle. When
//                   undefined, grants are held indefinitely and timeout is 0.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req[N]       request vector, bit i = requester i wants the resource
//   grant[N]     registered one-hot grant (all zero when idle)
//   grant_idx    registered binary index of the owner, 0 when idle
//   grant_valid  high while a grant is active
//   timeout      one-cycle pulse in the IDLE cycle after a forced revoke
//   state_dbg    current FSM state (0 = IDLE, 1 = GRANT) for checkers
//
// Handshake: a requester raises req[i] and keeps it high for its whole access.
// The grant appears one cycle after req is sampled in IDLE and stays fixed
// while req[grant_idx] is high; other requests never preempt it. Dropping
// req[grant_idx] is the release: the grant clears at the next edge, leaving
// one IDLE bubble cycle before the next grant is issued.
// -----------------------------------------------------------------------------
module penc_rr_arbiter #(
  parameter int N        = 4,
  parameter int IDX_W    = $clog2(N),
  parameter int MODE     = 0,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout,
  output logic             state_dbg
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ---------------------------------------------------------------------------
  if (N < 2) begin : g_bad_n
    $error("penc_rr_arbiter: N must be at least 2");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("penc_rr_arbiter: MAX_HOLD must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // FSM encoding
  // ---------------------------------------------------------------------------
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam logic [N-1:0] ONE_LSB = {{(N-1){1'b0}}, 1'b1};

  logic             state;
  logic [IDX_W-1:0] last_idx;

  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Fixed-priority encoder: highest set index wins. The ascending loop lets
  // later (higher) indices overwrite earlier ones.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] fp_idx;

  always_comb begin
    fp_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        fp_idx = IDX_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin encoder: search downward from last_idx-1, wrapping modulo N,
  // so that last_idx itself is visited last. With last_idx = 0 out of reset
  // the search starts at N-1 and matches fixed priority. Only indices below N
  // are ever produced, which keeps non-power-of-2 N in range.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] rr_idx;
  logic             rr_found;

  always_comb begin
    int cand;
    cand     = 0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_idx) + N - k) % N;
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(cand);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Winner selection and release detection
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] win_idx;
  logic [N-1:0]     win_onehot;
  logic             any_req;
  logic             owner_req;

  assign any_req    = |req;
  assign win_idx    = (MODE == 1) ? rr_idx : fp_idx;
  assign win_onehot = ONE_LSB << win_idx;
  assign owner_req  = req[grant_idx];

  // ---------------------------------------------------------------------------
  // Optional hold-time limiter
  // ---------------------------------------------------------------------------
  logic revoke;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] hold_cnt;

  // The counter holds the number of completed GRANT cycles minus one, so the
  // edge that ends the MAX_HOLD-th visible grant cycle sees MAX_HOLD-1.
  assign revoke = (state == ST_GRANT) && owner_req &&
                  (hold_cnt == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state == ST_IDLE) begin
      // Cleared on every entry to GRANT (and kept clear while idle).
      hold_cnt <= '0;
    end else if (owner_req && !revoke) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end
`else
  assign revoke = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Main FSM and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      last_idx    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // timeout is only ever high for the first IDLE cycle.
          timeout <= 1'b0;
          if (any_req) begin
            grant       <= win_onehot;
            grant_idx   <= win_idx;
            grant_valid <= 1'b1;
            state       <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          if (!owner_req || revoke) begin
            // Release (or forced revoke) is handled first; any competing
            // requests are arbitrated in the following IDLE cycle with the
            // updated last_idx.
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            last_idx    <= grant_idx;
            timeout     <= revoke;
            state       <= ST_IDLE;
          end
        end

        default: begin
          state       <= ST_IDLE;
          grant       <= '0;
          grant_idx   <= '0;
          grant_valid <= 1'b0;
          timeout     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_penc_rr_arbiter.sv
module tb_penc_rr_arbiter;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Fixed-priority DUT, N=4
  logic [3:0] req_fp = '0;
  logic [3:0] g_fp;
  logic [1:0] i_fp;
  logic       v_fp, t_fp, s_fp;

  // Round-robin DUT, N=4, MAX_HOLD=4
  logic [3:0] req_rr = '0;
  logic [3:0] g_rr;
  logic [1:0] i_rr;
  logic       v_rr, t_rr, s_rr;

  // Round-robin DUT, N=5 (non-power-of-2)
  logic [4:0] req_5 = '0;
  logic [4:0] g_5;
  logic [2:0] i_5;
  logic       v_5, t_5, s_5;

  penc_rr_arbiter #(.N(4), .MODE(0), .MAX_HOLD(16)) u_fp (
    .clk(clk), .rst_n(rst_n), .req(req_fp), .grant(g_fp), .grant_idx(i_fp),
    .grant_valid(v_fp), .timeout(t_fp), .state_dbg(s_fp));

  penc_rr_arbiter #(.N(4), .MODE(1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req_rr), .grant(g_rr), .grant_idx(i_rr),
    .grant_valid(v_rr), .timeout(t_rr), .state_dbg(s_rr));

  penc_rr_arbiter #(.N(5), .MODE(1), .MAX_HOLD(16)) u_5 (
    .clk(clk), .rst_n(rst_n), .req(req_5), .grant(g_5), .grant_idx(i_5),
    .grant_valid(v_5), .timeout(t_5), .state_dbg(s_5));

  // ---------------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full output check of one N=4 DUT against an expected index (valid=0 -> idle).
  task automatic chk_fp(input string tag, input logic ev, input logic [1:0] ei);
    chk({tag, ".grant"}, 32'(g_fp), ev ? 32'(4'b0001 << ei) : 32'd0);
    chk({tag, ".idx"},   32'(i_fp), ev ? 32'(ei) : 32'd0);
    chk({tag, ".valid"}, 32'(v_fp), 32'(ev));
  endtask

  task automatic chk_rr(input string tag, input logic ev, input logic [1:0] ei);
    chk({tag, ".grant"}, 32'(g_rr), ev ? 32'(4'b0001 << ei) : 32'd0);
    chk({tag, ".idx"},   32'(i_rr), ev ? 32'(ei) : 32'd0);
    chk({tag, ".valid"}, 32'(v_rr), 32'(ev));
  endtask

  // Structural invariants for the random phase.
  task automatic chk_inv(input string tag, input logic [31:0] g, input logic [31:0] idx,
                         input logic v, input logic pv, input logic [31:0] smp, input int n);
    logic [31:0] one;
    one = 32'd1;
    chk({tag, ".onehot"}, g, v ? (one << idx) : 32'd0);
    chk({tag, ".valid"},  32'(v), 32'(g != 0));
    chk({tag, ".range"},  32'(idx < 32'(n)), 32'd1);
    if (v && !pv) chk({tag, ".start_req"}, 32'(smp[idx[4:0]]), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed + random stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0] rr_exp [5];
    logic [3:0] s_fp_req, s_rr_req;
    logic [4:0] s_5_req;
    logic       pv_fp, pv_rr, pv_5;

    rr_exp[0] = 2'd3; rr_exp[1] = 2'd2; rr_exp[2] = 2'd1;
    rr_exp[3] = 2'd0; rr_exp[4] = 2'd3;

    // Reset state
    #12;
    chk_fp("reset_fp", 1'b0, 2'd0);
    chk("reset_fp.timeout", 32'(t_fp), 32'd0);
    chk("reset_fp.state", 32'(s_fp), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // MODE=0: req=0101 -> grant 2, held, then hand-off to 0 with one bubble
    req_fp = 4'b0101;
    step();
    chk_fp("fp_first", 1'b1, 2'd2);
    chk("fp_first.state", 32'(s_fp), 32'd1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk_fp("fp_hold", 1'b1, 2'd2);
    end
    req_fp = 4'b0001;
    step();
    chk_fp("fp_bubble", 1'b0, 2'd0);
    step();
    chk_fp("fp_next", 1'b1, 2'd0);
    req_fp = 4'b0000;
    step();
    chk_fp("fp_release", 1'b0, 2'd0);
    step();

    // MODE=0 starvation: owner 3 re-raises immediately -> 3,3,3
    req_fp = 4'b1111;
    step();
    chk_fp("fp_starve0", 1'b1, 2'd3);
    for (int r = 0; r < 2; r++) begin
      req_fp = 4'b0111;
      step();
      chk_fp("fp_starve_bub", 1'b0, 2'd0);
      req_fp = 4'b1111;
      step();
      chk_fp("fp_starve", 1'b1, 2'd3);
    end
    req_fp = 4'b0000;
    step();
    step();

    // MODE=1 same stimulus -> 3,2,1,0,3
    req_rr = 4'b1111;
    step();
    chk_rr("rr_seq0", 1'b1, rr_exp[0]);
    for (int r = 1; r < 5; r++) begin
      req_rr = 4'b1111 & ~(4'b0001 << rr_exp[r-1]);
      step();
      chk_rr("rr_seq_bub", 1'b0, 2'd0);
      req_rr = 4'b1111;
      step();
      chk_rr("rr_seq", 1'b1, rr_exp[r]);
    end
    req_rr = 4'b0000;
    step();
    chk_rr("rr_drop", 1'b0, 2'd0);
    step();

    // MODE=1: owner 2 drops as 0 and 3 rise -> bubble, then 0
    req_rr = 4'b0100;
    step();
    chk_rr("rr_own2", 1'b1, 2'd2);
    req_rr = 4'b1001;
    step();
    chk_rr("rr_simul_bub", 1'b0, 2'd0);
    step();
    chk_rr("rr_simul_win", 1'b1, 2'd0);
    req_rr = 4'b0000;
    step();
    step();

    // Long hold: forced revoke with the limiter, indefinite hold without it
    req_rr = 4'b0010;
    step();
`ifdef ARB_TIMEOUT_EN
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        chk_rr("to_grant", 1'b1, 2'd1);
        chk("to_grant.timeout", 32'(t_rr), 32'd0);
        step();
      end
      chk_rr("to_revoke", 1'b0, 2'd0);
      chk("to_revoke.timeout", 32'(t_rr), 32'd1);
      step();
    end
    chk_rr("to_regrant", 1'b1, 2'd1);
    chk("to_regrant.timeout", 32'(t_rr), 32'd0);
`else
    for (int c = 0; c < 10; c++) begin
      chk_rr("hold_forever", 1'b1, 2'd1);
      chk("hold_forever.timeout", 32'(t_rr), 32'd0);
      step();
    end
`endif

    // Asynchronous reset mid-grant clears outputs before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    chk_rr("async_rst", 1'b0, 2'd0);
    chk("async_rst.timeout", 32'(t_rr), 32'd0);
    chk("async_rst.state", 32'(s_rr), 32'd0);
    req_rr = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // N=5: first arbitration picks index 4, then wraps 3 -> ... -> 4 again
    req_5 = 5'b10001;
    step();
    chk("n5_first.idx", 32'(i_5), 32'd4);
    chk("n5_first.grant", 32'(g_5), 32'h10);
    req_5 = 5'b00001;
    step();
    chk("n5_bub.valid", 32'(v_5), 32'd0);
    req_5 = 5'b10001;
    step();
    chk("n5_wrap.idx", 32'(i_5), 32'd0);
    req_5 = 5'b10000;
    step();
    step();
    chk("n5_back.idx", 32'(i_5), 32'd4);
    req_5 = 5'b00000;
    step();
    step();

    // Random phase: structural invariants on all DUTs
    pv_fp = v_fp; pv_rr = v_rr; pv_5 = v_5;
    for (int c = 0; c < 10000; c++) begin
      s_fp_req = req_fp; s_rr_req = req_rr; s_5_req = req_5;
      step();
      chk_inv("rnd_fp", 32'(g_fp), 32'(i_fp), v_fp, pv_fp, 32'(s_fp_req), 4);
      chk_inv("rnd_rr", 32'(g_rr), 32'(i_rr), v_rr, pv_rr, 32'(s_rr_req), 4);
      chk_inv("rnd_5",  32'(g_5),  32'(i_5),  v_5,  pv_5,  32'(s_5_req),  5);
`ifndef ARB_TIMEOUT_EN
      chk("rnd_rr.timeout", 32'(t_rr), 32'd0);
`endif
      pv_fp = v_fp; pv_rr = v_rr; pv_5 = v_5;
      req_fp = 4'($urandom_range(0, 15));
      req_rr = 4'($urandom_range(0, 15));
      req_5  = 5'($urandom_range(0, 31));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/penc_rr_arbiter.md
Name: penc_rr_arbiter

Overview:
- Parametrised N-requester arbiter built around a priority-encoder core. Generalises the 4:2 priority encoder to N inputs.
- Adds registered outputs, a grant-hold handshake and a selectable fixed-priority or round-robin mode.
- Sits in front of any shared resource (bus, memory port) whose clients raise a request line and hold it for the duration of their access.

Parameters:
- N, 4, number of requesters (≥2).
- IDX_W, $clog2(N), width of the encoded grant index (derived; do not override).
- MODE, 0, arbitration mode: 0 = fixed priority (highest index wins), 1 = round-robin.
- MAX_HOLD, 16, maximum grant duration in cycles. Used only when ARB_TIMEOUT_EN is defined; must be ≥1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector; bit i = requester i wants the resource.
- grant  output  N  one-hot grant, registered.
- grant_idx  output  IDX_W  binary index of the granted requester, registered; 0 when no grant.
- grant_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-revoked; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset (asynchronous, on rst_n low): grant=0, grant_idx=0, grant_valid=0, timeout=0, state=IDLE, last_idx=0, hold counter=0. Reset asserted mid-grant clears all outputs immediately, without waiting for a clock edge.
- State IDLE:
  - If req≠0 at a rising edge, select a winner, register grant/grant_idx/grant_valid=1, and go to GRANT.
  - Latency from req sampled to grant visible: 1 cycle.
  - If req=0, remain in IDLE with outputs 0.
- Winner selection, MODE=0: highest set index of req, same as the priority encoder.
- Winner selection, MODE=1:
  - Search downward starting at last_idx-1 (mod N), wrapping; last_idx has lowest priority.
  - With last_idx=0 after reset, the search starts at N-1, so the first arbitration matches fixed priority.
- State GRANT:
  - Grant is held unchanged while req[grant_idx]=1. Other req bits are ignored; no preemption.
  - When req[grant_idx]=0 at an edge: clear grant/grant_idx/grant_valid, set last_idx=released index, return to IDLE.
  - Exactly one bubble cycle with grant_valid=0 occurs between consecutive grants.
- Simultaneous release by the owner and new requests from others: the release is processed first. The new winner is chosen in the following IDLE cycle using the updated last_idx.
- grant is always one-hot or zero. grant_idx always equals the encoded value of grant.
- Request bits ≥N do not exist. A non-power-of-2 N never produces grant_idx ≥ N.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - The hold counter increments on each GRANT cycle.
  - When the grant has been held MAX_HOLD cycles and req[grant_idx] is still 1, the block revokes the grant as for a release: last_idx updated, return to IDLE.
  - timeout=1 for exactly the first IDLE cycle after revocation.
  - Counter clears on every entry to GRANT.
  - A requester that still holds req after revocation competes normally; in MODE=1 it is lowest priority.
- Not defined: no counter is present, grants are held indefinitely, and timeout is tied to 0.

Test Plan:
- Reset with req=0000, N=4 -> grant=0000, grant_idx=00, grant_valid=0, timeout=0. Assert rst_n=0 mid-grant -> outputs go to 0 before the next clock edge.
- MODE=0, req=0101 -> after 1 edge grant=0100, grant_idx=10. Hold req[2] 5 cycles -> grant stable. Then req=0001 -> 1 cycle grant=0000, next cycle grant=0001, grant_idx=00.
- MODE=0, every requester re-raises req=1111 immediately after its release -> grants 3,3,3 (starvation confirmed). MODE=1, same stimulus -> grant sequence 3,2,1,0,3 with one bubble between each.
- MODE=1, owner 2 drops req in the same cycle req[0] and req[3] rise -> bubble, then grant=0001 (index 0 precedes 3 when last_idx=2).
- ARB_TIMEOUT_EN, MAX_HOLD=4, MODE=1, req=0010 held constantly -> grant_valid high 4 cycles, then timeout=1 for 1 cycle with grant=0, then grant=0010 again, and the pattern repeats.
- Random req for 10k cycles in both modes -> checker confirms grant is one-hot or zero, grant_idx matches grant, and there is no grant to a non-requesting index at grant start.
